// File: rtl/fixed_matmul_sched_pkg.sv
// Shared types for the matmul tile scheduler: FSM state encoding and
// the tile-address width helper.
package fixed_matmul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // clog2 that never returns zero, so single-tile dimensions still get a 1-bit field.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fixed_matmul_tile_counter.sv
// Nested k/c/r wrap counter (k innermost); exposes the post-advance values and a final-beat flag.
// Latency: next values are combinational from the registered counters; clear wins over advance.
// Backpressure: counters only move when adv is high.
module fixed_matmul_tile_counter
    import fixed_matmul_sched_pkg::*;
#(
    parameter int ROW_TILES   = 2,
    parameter int COL_TILES   = 3,
    parameter int DEPTH_TILES = 4,
    parameter int RW          = addr_w(ROW_TILES),
    parameter int CW          = addr_w(COL_TILES),
    parameter int KW          = addr_w(DEPTH_TILES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [KW-1:0] k_nxt,
    output logic [CW-1:0] c_nxt,
    output logic [RW-1:0] r_nxt,
    output logic          last_beat
);

    logic [KW-1:0] k;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic          k_wrap;
    logic          c_wrap;
    logic          r_wrap;

    assign k_wrap    = (k == KW'(DEPTH_TILES - 1));
    assign c_wrap    = (c == CW'(COL_TILES - 1));
    assign r_wrap    = (r == RW'(ROW_TILES - 1));
    assign last_beat = k_wrap & c_wrap & r_wrap;

    always_comb begin
        k_nxt = k;
        c_nxt = c;
        r_nxt = r;
        if (clr) begin
            k_nxt = '0;
            c_nxt = '0;
            r_nxt = '0;
        end else if (adv) begin
            if (!k_wrap) begin
                k_nxt = k + 1'b1;
            end else begin
                k_nxt = '0;
                if (!c_wrap) begin
                    c_nxt = c + 1'b1;
                end else begin
                    c_nxt = '0;
                    r_nxt = r_wrap ? '0 : r + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            c <= '0;
            r <= '0;
        end else begin
            k <= k_nxt;
            c <= c_nxt;
            r <= r_nxt;
        end
    end

endmodule

// File: rtl/fixed_matmul_tile_scheduler.sv
// Issues one operand tile-fetch beat per accepted handshake over the full tile grid, credit-limiting output tiles.
// Latency: first req_valid one cycle after start; done one cycle after the final completion is registered.
// Backpressure: req_* hold while req_valid & !req_ready; optional stall_cycles via FIXED_MATMUL_SCHED_PERF_EN.
module fixed_matmul_tile_scheduler
    import fixed_matmul_sched_pkg::*;
#(
    parameter int ROW_TILES       = 2,
    parameter int COL_TILES       = 3,
    parameter int DEPTH_TILES     = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int A1_WIDTH        = addr_w(ROW_TILES * DEPTH_TILES),
    parameter int A2_WIDTH        = addr_w(DEPTH_TILES * COL_TILES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [A1_WIDTH-1:0] req_in1_addr,
    output logic [A2_WIDTH-1:0] req_in2_addr,
    output logic                req_first,
    output logic                req_last,
    output logic                req_valid,
    input  logic                req_ready,
    input  logic                out_tile_valid,
    input  logic                out_tile_ready
`ifdef FIXED_MATMUL_SCHED_PERF_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int TOTAL = ROW_TILES * COL_TILES;
    localparam int NW    = $clog2(TOTAL + MAX_OUTSTANDING + 1);
    localparam int RW    = addr_w(ROW_TILES);
    localparam int CW    = addr_w(COL_TILES);
    localparam int KW    = addr_w(DEPTH_TILES);

    sched_state_t  state;
    logic [NW-1:0] issued;
    logic [NW-1:0] completed;
    logic [NW-1:0] issued_nxt;
    logic [NW-1:0] completed_nxt;
    logic [KW-1:0] k_nxt;
    logic [CW-1:0] c_nxt;
    logic [RW-1:0] r_nxt;
    logic          last_beat;
    logic          accept;
    logic          start_go;
    logic          cmpl;
    logic          credit_ok;
    logic          first_nxt;
    logic          last_nxt;
    logic [A1_WIDTH-1:0] a1_nxt;
    logic [A2_WIDTH-1:0] a2_nxt;

    assign accept        = req_valid & req_ready;
    assign start_go      = (state == IDLE) & start;
    assign cmpl          = out_tile_valid & out_tile_ready & (state != IDLE) & (completed != NW'(TOTAL));
    assign issued_nxt    = issued + NW'(accept & req_last);
    assign completed_nxt = completed + NW'(cmpl);
    // Outstanding is judged on this cycle's updated counts so a completion frees credit immediately.
    assign credit_ok     = issued_nxt < (completed_nxt + NW'(MAX_OUTSTANDING));
    assign first_nxt     = (k_nxt == '0);
    assign last_nxt      = (k_nxt == KW'(DEPTH_TILES - 1));
    assign a1_nxt        = A1_WIDTH'(int'(r_nxt) * DEPTH_TILES + int'(k_nxt));
    assign a2_nxt        = A2_WIDTH'(int'(k_nxt) * COL_TILES + int'(c_nxt));

    fixed_matmul_tile_counter #(
        .ROW_TILES   (ROW_TILES),
        .COL_TILES   (COL_TILES),
        .DEPTH_TILES (DEPTH_TILES)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_go),
        .adv       (accept),
        .k_nxt     (k_nxt),
        .c_nxt     (c_nxt),
        .r_nxt     (r_nxt),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            req_valid    <= 1'b0;
            req_in1_addr <= '0;
            req_in2_addr <= '0;
            req_first    <= 1'b0;
            req_last     <= 1'b0;
            issued       <= '0;
            completed    <= '0;
        end else begin
            done      <= 1'b0;
            issued    <= issued_nxt;
            completed <= completed_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        issued       <= '0;
                        completed    <= '0;
                        req_valid    <= 1'b1;
                        req_in1_addr <= a1_nxt;
                        req_in2_addr <= a2_nxt;
                        req_first    <= first_nxt;
                        req_last     <= last_nxt;
                    end
                end
                ISSUE: begin
                    if (accept && last_beat) begin
                        state     <= DRAIN;
                        req_valid <= 1'b0;
                    end else if (!req_valid || req_ready) begin
                        // Only the first beat of a tile waits for credit.
                        req_valid    <= !first_nxt || credit_ok;
                        req_in1_addr <= a1_nxt;
                        req_in2_addr <= a2_nxt;
                        req_first    <= first_nxt;
                        req_last     <= last_nxt;
                    end
                end
                DRAIN: begin
                    if (completed == NW'(TOTAL)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIXED_MATMUL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            stall_cycles <= '0;
        end else if (state == ISSUE && !accept && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fixed_matmul_tile_scheduler.sv
// Directed bench: three scheduler instances (2x3x4 credit 2, 2x3x4 credit 1, 1x1x1).
module tb_fixed_matmul_tile_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    logic       a_start = 0, a_busy, a_done, a_first, a_last, a_vld, a_rdy = 1, a_ov = 0, a_ordy = 1;
    logic [2:0] a_a1;
    logic [3:0] a_a2;
    logic       b_start = 0, b_busy, b_done, b_first, b_last, b_vld, b_rdy = 1, b_ov = 0, b_ordy = 1;
    logic [2:0] b_a1;
    logic [3:0] b_a2;
    logic       d_start = 0, d_busy, d_done, d_first, d_last, d_vld, d_rdy = 1, d_ov = 0, d_ordy = 1;
    logic [0:0] d_a1;
    logic [0:0] d_a2;
`ifdef FIXED_MATMUL_SCHED_PERF_EN
    logic [31:0] a_stall, b_stall, d_stall;
`endif

    fixed_matmul_tile_scheduler dut_a (
        .clk (clk), .rst (rst), .start (a_start), .busy (a_busy), .done (a_done),
        .req_in1_addr (a_a1), .req_in2_addr (a_a2), .req_first (a_first), .req_last (a_last),
        .req_valid (a_vld), .req_ready (a_rdy), .out_tile_valid (a_ov), .out_tile_ready (a_ordy)
`ifdef FIXED_MATMUL_SCHED_PERF_EN
        , .stall_cycles (a_stall)
`endif
    );

    fixed_matmul_tile_scheduler #(.MAX_OUTSTANDING (1)) dut_b (
        .clk (clk), .rst (rst), .start (b_start), .busy (b_busy), .done (b_done),
        .req_in1_addr (b_a1), .req_in2_addr (b_a2), .req_first (b_first), .req_last (b_last),
        .req_valid (b_vld), .req_ready (b_rdy), .out_tile_valid (b_ov), .out_tile_ready (b_ordy)
`ifdef FIXED_MATMUL_SCHED_PERF_EN
        , .stall_cycles (b_stall)
`endif
    );

    fixed_matmul_tile_scheduler #(.ROW_TILES (1), .COL_TILES (1), .DEPTH_TILES (1)) dut_d (
        .clk (clk), .rst (rst), .start (d_start), .busy (d_busy), .done (d_done),
        .req_in1_addr (d_a1), .req_in2_addr (d_a2), .req_first (d_first), .req_last (d_last),
        .req_valid (d_vld), .req_ready (d_rdy), .out_tile_valid (d_ov), .out_tile_ready (d_ordy)
`ifdef FIXED_MATMUL_SCHED_PERF_EN
        , .stall_cycles (d_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full 2x3x4 run on dut_a with immediate completions; optional ready hold on one beat.
    task automatic run_a(input int hold_beat, input int hold_len, input string tag);
        int n, held, dones, last_cyc;
        n = 0; held = 0; dones = 0; last_cyc = -1;
        a_start = 1; tick(); a_start = 0;
        for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
            a_rdy = !(n == hold_beat && held < hold_len);
            if (a_vld) begin
                check($sformatf("%s_a1[%0d]", tag, n), a_a1, (n / 12) * 4 + (n % 4));
                check($sformatf("%s_a2[%0d]", tag, n), a_a2, (n % 4) * 3 + ((n / 4) % 3));
                check($sformatf("%s_first[%0d]", tag, n), a_first, (n % 4) == 0);
                check($sformatf("%s_last[%0d]", tag, n), a_last, (n % 4) == 3);
            end
            a_ov = a_vld && a_rdy && a_last;
            if (a_vld && a_rdy) begin
                n++;
                last_cyc = cyc;
            end
            if (!a_rdy) held++;
            tick();
            if (a_done) dones++;
        end
        a_ov = 0; a_rdy = 1;
        check({tag, "_beats"}, n, 24);
        check({tag, "_last_cycle"}, last_cyc, 23 + hold_len);
        check({tag, "_done_seen"}, dones, 1);
`ifdef FIXED_MATMUL_SCHED_PERF_EN
        check({tag, "_stalls"}, a_stall, hold_len);
`endif
        tick();
        check({tag, "_done_once"}, a_done, 0);
        check({tag, "_busy_end"}, a_busy, 0);
        check({tag, "_vld_end"}, a_vld, 0);
    endtask

    initial begin
        tick(); tick();
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_vld", a_vld, 0);
        check("rst_a_a1", a_a1, 0);
        check("rst_a_a2", a_a2, 0);
        check("rst_a_first", a_first, 0);
        check("rst_b_vld", b_vld, 0);
        check("rst_d_busy", d_busy, 0);
        rst = 0;
        tick();

        run_a(-1, 0, "run");

        // Tile 1 completion withheld until it coincides with tile 2's last beat.
        a_start = 1; tick(); a_start = 0;
        repeat (7) tick();
        check("sim_pre_last", a_last, 1);
        a_ov = 1; tick(); a_ov = 0;
        check("sim_vld", a_vld, 1);
        check("sim_first", a_first, 1);
        check("sim_a1", a_a1, 0);
        check("sim_a2", a_a2, 2);
        tick(); tick();
        rst = 1; tick(); rst = 0;
        check("abort_busy", a_busy, 0);
        check("abort_vld", a_vld, 0);
        check("abort_done", a_done, 0);
        check("abort_a1", a_a1, 0);
        tick(); tick();
        check("abort_vld_idle", a_vld, 0);
        check("abort_no_done", a_done, 0);

        run_a(1, 5, "bp");

        // Credit of one: second tile waits for the first completion.
        b_start = 1; tick(); b_start = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cr_vld%0d", i), b_vld, 1);
            tick();
        end
        check("cr_drop", b_vld, 0);
        tick(); tick();
        check("cr_hold", b_vld, 0);
        check("cr_busy", b_busy, 1);
        b_ov = 1; b_ordy = 0; tick(); b_ov = 0; b_ordy = 1;
        check("cr_no_handshake", b_vld, 0);
        b_ov = 1; tick(); b_ov = 0;
        check("cr_resume", b_vld, 1);
        check("cr_first", b_first, 1);
        check("cr_a1", b_a1, 0);
        check("cr_a2", b_a2, 1);
`ifdef FIXED_MATMUL_SCHED_PERF_EN
        check("cr_stalls", b_stall, 4);
`endif

        // Single-tile grid.
        d_start = 1; tick(); d_start = 0;
        check("dg_vld", d_vld, 1);
        check("dg_a1", d_a1, 0);
        check("dg_a2", d_a2, 0);
        check("dg_first", d_first, 1);
        check("dg_last", d_last, 1);
        check("dg_busy", d_busy, 1);
        tick();
        check("dg_vld_after", d_vld, 0);
        d_start = 1; tick(); d_start = 0;
        d_ov = 1; tick(); d_ov = 0;
        check("dg_done_early", d_done, 0);
        tick();
        check("dg_done", d_done, 1);
        tick();
        check("dg_done_once", d_done, 0);
        check("dg_busy_end", d_busy, 0);
        check("dg_vld_end", d_vld, 0);
        tick();
        check("dg_no_restart", d_vld, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
